// File: rtl/l2_if_pkg.sv
// Shared definitions for the L1<->L2 line-fill / writeback interface.
package l2_if_pkg;

  localparam int unsigned LineWords = 8;
  localparam int unsigned WordW     = 32;
  localparam int unsigned LineW     = 256;
  localparam int unsigned OffsetW   = 5;

  // Encoding is visible on the debug state port, so values are fixed.
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StWrBurst = 3'd1,
    StRdWait  = 3'd2,
    StRdAck   = 3'd3,
    StRdHold  = 3'd4
  } l2_state_e;

endpackage

// File: rtl/l2_word_ram.sv
// Word-addressed backing store: one synchronous write port and a full-line
// combinational read of the eight words at a line index.
module l2_word_ram
  import l2_if_pkg::*;
#(
  parameter int unsigned MemWords = 1024
) (
  input  logic                          clk_i,
  input  logic                          we_i,
  input  logic [$clog2(MemWords)-1:0]   waddr_i,
  input  logic [WordW-1:0]              wdata_i,
  input  logic [$clog2(MemWords)-4:0]   rline_i,
  output logic [LineW-1:0]              rdata_o
);

  logic [WordW-1:0] mem_q [MemWords];

  // Word write; contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Eight parallel read ports, word i of the line at bits [32i +: 32].
  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < LineWords; i++) begin
      rdata_o[i*WordW +: WordW] = mem_q[{rline_i, 3'(i)}];
    end
  end

endmodule

// File: rtl/l2_responder.sv
// L2-side responder: services 8-word line fills with programmable latency
// and 8-beat (or partial / wrapping) write bursts into the backing array.
module l2_responder
  import l2_if_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned READ_LAT  = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             read_l2_i,
  input  logic             write_l2_i,
  input  logic [31:0]      addr_i,
  input  logic [31:0]      wdata_i,
  output logic             l2_ack_o,
  output logic [LineW-1:0] rdata_o,
  output logic             busy_o,
  output logic [2:0]       state_o
);

  localparam int unsigned AddrW    = $clog2(MEM_WORDS);
  localparam int unsigned LineIdxW = AddrW - 3;
  localparam int unsigned LatW     = $clog2(READ_LAT + 1);

  l2_state_e             state_q, state_d;
  logic [LineIdxW-1:0]   line_q, line_d;
  logic [2:0]            beat_q, beat_d;
  logic [LatW-1:0]       wait_q, wait_d;
  logic [LineW-1:0]      rdata_q, rdata_d;

  logic                  ram_we;
  logic [AddrW-1:0]      ram_waddr;
  logic [LineW-1:0]      ram_line;
  logic [LineIdxW-1:0]   addr_line;

  // Upper address bits are dropped, so addresses alias modulo the array size.
  assign addr_line = addr_i[AddrW+1:OffsetW];

  l2_word_ram #(
    .MemWords (MEM_WORDS)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (wdata_i),
    .rline_i (line_q),
    .rdata_o (ram_line)
  );

  // Next-state logic and array write control.
  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    beat_d    = beat_q;
    wait_d    = wait_q;
    rdata_d   = rdata_q;
    ram_we    = 1'b0;
    ram_waddr = {line_q, beat_q};
    unique case (state_q)
      StIdle: begin
        if (write_l2_i) begin
          line_d    = addr_line;
          ram_we    = 1'b1;
          ram_waddr = {addr_line, 3'd0};
          beat_d    = 3'd1;
          state_d   = StWrBurst;
        end else if (read_l2_i) begin
          line_d  = addr_line;
          wait_d  = '0;
          state_d = StRdWait;
        end
      end
      StWrBurst: begin
        if (write_l2_i) begin
          ram_we = 1'b1;
          beat_d = beat_q + 3'd1;  // wraps mod 8
        end else begin
          state_d = StIdle;
        end
      end
      StRdWait: begin
        // Terminal count READ_LAT puts the ack READ_LAT+1 edges after acceptance.
        if (wait_q == LatW'(READ_LAT)) begin
          rdata_d = ram_line;
          state_d = StRdAck;
        end else begin
          wait_d = wait_q + LatW'(1);
        end
      end
      StRdAck: begin
        state_d = StRdHold;
      end
      StRdHold: begin
        if (!read_l2_i) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    // A reset edge must not store the beat presented alongside it.
    if (reset_i) begin
      ram_we = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      line_q  <= '0;
      beat_q  <= '0;
      wait_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      rdata_q <= rdata_d;
    end
  end

  assign l2_ack_o = (state_q == StRdAck);
  assign rdata_o  = rdata_q;
  assign busy_o   = (state_q != StIdle);
  assign state_o  = state_q;

endmodule
